// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage for the decode->execute path: widens an immediate in one of
// four modes and delivers it, with its tag, through a registered valid/ready output
// backed by a one-entry skid buffer.
module imm_ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHIFT = 2,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [1:0] OP_ZERO   = 2'b00;
   localparam logic [1:0] OP_SIGN   = 2'b01;
   localparam logic [1:0] OP_UPPER  = 2'b10;
   localparam logic [1:0] OP_BRANCH = 2'b11;

   logic [OUT_W-1:0] w_zext;
   logic [OUT_W-1:0] w_sext;
   logic [OUT_W-1:0] w_upper;
   logic [OUT_W-1:0] w_branch;
   logic [OUT_W-1:0] w_ext;
   logic             w_in_xfer;
   logic             w_out_xfer;

   logic             r_out_valid;
   logic [OUT_W-1:0] r_out_data;
   logic [TAG_W-1:0] r_out_tag;
   logic             r_skid_valid;
   logic [OUT_W-1:0] r_skid_data;
   logic [TAG_W-1:0] r_skid_tag;

   assign w_zext   = {{(OUT_W-IN_W){1'b0}}, in_imm};
   assign w_sext   = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
   assign w_upper  = {in_imm, {(OUT_W-IN_W){1'b0}}};
   // Bits shifted past the MSB of the sign-extended value are intentionally dropped.
   assign w_branch = w_sext << SHIFT;

   always_comb begin
      w_ext = w_zext;
      case (in_op)
         OP_ZERO:   w_ext = w_zext;
         OP_SIGN:   w_ext = w_sext;
         OP_UPPER:  w_ext = w_upper;
         OP_BRANCH: w_ext = w_branch;
         default:   w_ext = w_zext;
      endcase
   end

   // Ready depends only on registered state, so out_ready never reaches in_ready.
   assign in_ready   = rst_n && !r_skid_valid;
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = r_out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_tag    <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_tag   <= '0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_out_valid || w_out_xfer) begin
         if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= r_skid_data;
            r_out_tag    <= r_skid_tag;
            r_skid_valid <= w_in_xfer;
            if (w_in_xfer) begin
               r_skid_data <= w_ext;
               r_skid_tag  <= in_tag;
            end
         end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_ext;
            r_out_tag   <= in_tag;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (w_in_xfer) begin
         r_skid_valid <= 1'b1;
         r_skid_data  <= w_ext;
         r_skid_tag   <= in_tag;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: default-parameter instance checked through a scoreboard plus
// directed checks, and a 12/24/1 instance checked against fixed constants.
module tb_imm_ext_pipe;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_imm;
   logic [1:0]  in_op;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_tag;

   logic        p_in_valid;
   logic        p_in_ready;
   logic [11:0] p_in_imm;
   logic [1:0]  p_in_op;
   logic [4:0]  p_in_tag;
   logic        p_out_valid;
   logic [23:0] p_out_data;
   logic [4:0]  p_out_tag;

   int n_checks = 0;
   int n_pass   = 0;
   logic [36:0] exp_q[$];

   imm_ext_pipe dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
   );

   imm_ext_pipe #(.IN_W(12), .OUT_W(24), .SHIFT(1), .TAG_W(5)) dut_p (
      .clk(clk), .rst_n(rst_n), .flush(1'b0),
      .in_valid(p_in_valid), .in_ready(p_in_ready), .in_imm(p_in_imm), .in_op(p_in_op),
      .in_tag(p_in_tag), .out_valid(p_out_valid), .out_ready(1'b1), .out_data(p_out_data),
      .out_tag(p_out_tag)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] op);
      int s;
      s = int'($signed(imm));
      case (op)
         2'd0:    return {16'h0000, imm};
         2'd1:    return s;
         2'd2:    return {imm, 16'h0000};
         default: return 32'(s * 4);
      endcase
   endfunction

   // scoreboard: push on input transfer, pop on output transfer
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("sb_spurious", {63'd0, out_valid}, 64'd0);
            end else begin
               logic [36:0] e;
               e = exp_q.pop_front();
               check_eq("sb_tag", out_tag, e[36:32]);
               check_eq("sb_data", out_data, e[31:0]);
            end
         end
         if (flush) exp_q.delete();
         else if (in_valid && in_ready) exp_q.push_back({in_tag, ref_ext(in_imm, in_op)});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] imm, input logic [1:0] op, input logic [4:0] tag);
      in_valid = 1'b1;
      in_imm   = imm;
      in_op    = op;
      in_tag   = tag;
   endtask

   task automatic mode_beat(input logic [15:0] imm, input logic [1:0] op, input logic [31:0] exp);
      drive(imm, op, 5'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("mode_valid", {63'd0, out_valid}, 64'd1);
      check_eq("mode_data", out_data, exp);
      tick();
   endtask

   task automatic p_beat(input logic [1:0] op, input logic [23:0] exp);
      p_in_valid = 1'b1;
      p_in_imm   = 12'h800;
      p_in_op    = op;
      tick();
      p_in_valid = 1'b0;
      @(negedge clk);
      check_eq("p12_valid", {63'd0, p_out_valid}, 64'd1);
      check_eq("p12_data", p_out_data, exp);
      tick();
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_op = '0; in_tag = '0;
      out_ready = 1'b1;
      p_in_valid = 1'b0; p_in_imm = '0; p_in_op = '0; p_in_tag = 5'd3;
      repeat (3) tick();
      @(negedge clk);
      check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_out_data", out_data, 64'd0);
      check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rel_in_ready", {63'd0, in_ready}, 64'd1);
      tick();

      // extension modes
      mode_beat(16'h8001, 2'b00, 32'h0000_8001);
      mode_beat(16'h8001, 2'b01, 32'hFFFF_8001);
      mode_beat(16'h8001, 2'b10, 32'h8001_0000);
      mode_beat(16'h8001, 2'b11, 32'hFFFE_0004);
      mode_beat(16'h7FFF, 2'b11, 32'h0001_FFFC);

      // streaming
      for (int i = 0; i < 8; i++) begin
         drive(16'($urandom_range(0, 16'hFFFF)), 2'($urandom_range(0, 3)), 5'(i));
         @(negedge clk);
         check_eq("stream_ready", {63'd0, in_ready}, 64'd1);
         if (i > 0) check_eq("stream_valid", {63'd0, out_valid}, 64'd1);
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("stream_last", {63'd0, out_valid}, 64'd1);
      repeat (2) tick();

      // back-pressure
      out_ready = 1'b0;
      drive(16'h1234, 2'b01, 5'd0);
      @(negedge clk);
      check_eq("bp_rdy0", {63'd0, in_ready}, 64'd1);
      tick();
      drive(16'h8765, 2'b11, 5'd1);
      @(negedge clk);
      check_eq("bp_rdy1", {63'd0, in_ready}, 64'd1);
      tick();
      drive(16'h00F0, 2'b10, 5'd2);
      @(negedge clk);
      check_eq("bp_rdy_low", {63'd0, in_ready}, 64'd0);
      tick();
      @(negedge clk);
      check_eq("bp_hold_rdy", {63'd0, in_ready}, 64'd0);
      check_eq("bp_hold_tag", out_tag, 64'd0);
      check_eq("bp_hold_data", out_data, 64'h0000_1234);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_out0", out_tag, 64'd0);
      tick();
      @(negedge clk);
      check_eq("bp_rdy_rise", {63'd0, in_ready}, 64'd1);
      check_eq("bp_out1", out_tag, 64'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("bp_out2", out_tag, 64'd2);
      check_eq("bp_out2_valid", {63'd0, out_valid}, 64'd1);
      repeat (2) tick();

      // flush with main and skid full
      out_ready = 1'b0;
      drive(16'h0A0A, 2'b00, 5'd10);
      tick();
      drive(16'h0B0B, 2'b01, 5'd11);
      tick();
      drive(16'h0C0C, 2'b00, 5'd12);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("flush_valid", {63'd0, out_valid}, 64'd0);
      check_eq("flush_ready", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      // flush while ready: the offered input must still be discarded
      drive(16'h0D0D, 2'b00, 5'd13);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("flush_rdy_valid", {63'd0, out_valid}, 64'd0);
      repeat (3) tick();

      // reset mid-stream with two entries held
      out_ready = 1'b0;
      drive(16'h5555, 2'b01, 5'd20);
      tick();
      drive(16'hAAAA, 2'b10, 5'd21);
      tick();
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("rst_mid_rdy_low", {63'd0, in_ready}, 64'd0);
      tick();
      @(negedge clk);
      check_eq("rst_mid_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_mid_data", out_data, 64'd0);
      check_eq("rst_mid_tag", out_tag, 64'd0);
      check_eq("rst_mid_rdy", {63'd0, in_ready}, 64'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_rel_rdy", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      repeat (3) tick();

      // 12/24/1 instance
      p_beat(2'b01, 24'hFFF800);
      p_beat(2'b11, 24'hFFF000);
      p_beat(2'b10, 24'h800000);

      @(negedge clk);
      check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Pipelined, parametrised immediate-extension stage for the decode→execute path of the pipelined MIPS core. It widens an IN_W-bit immediate to OUT_W bits in one of four modes: zero-extend, sign-extend, upper-load, and sign-extend with a left shift for branch offsets. It carries a side tag with each result. Results leave through a registered valid/ready interface backed by a one-entry skid buffer, so back-pressure from execute never drops or duplicates an immediate.

## Interface
- IN_W, 16, immediate input width
- OUT_W, 32, extended output width; OUT_W ≥ IN_W + SHIFT
- SHIFT, 2, left-shift amount applied in branch mode
- TAG_W, 5, width of the side tag carried with each immediate (e.g. destination register)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- flush  in  1  synchronous pipeline flush from the hazard unit
- in_valid  in  1  input immediate valid
- in_ready  out  1  stage can accept an input this cycle
- in_imm  in  IN_W  raw immediate
- in_op  in  2  extension mode: 00 zero, 01 sign, 10 upper, 11 branch
- in_tag  in  TAG_W  side tag
- out_valid  out  1  output result valid
- out_ready  in  1  downstream accepts the result this cycle
- out_data  out  OUT_W  extended immediate
- out_tag  out  TAG_W  tag associated with out_data

## Operation
- Mode arithmetic, with x = in_imm:
  - 00 zero: {(OUT_W−IN_W) zeros, x}.
  - 01 sign: {(OUT_W−IN_W) copies of x[IN_W−1], x}.
  - 10 upper: {x, (OUT_W−IN_W) zeros}. For IN_W=16/OUT_W=32 this is LUI.
  - 11 branch: sign-extend x to OUT_W, then shift left by SHIFT. The result is truncated to OUT_W bits, and the top bits of the sign-extended value are discarded.
- Storage: a main output register (out_valid/out_data/out_tag) plus one skid entry (skid_valid/skid_data/skid_tag).
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- in_ready = rst_n && !skid_valid. It is derived from registered state only and has no combinational path from out_ready.
- Next-state rules, evaluated each clock when rst_n=1 and flush=0:
  - Main register empty or output transfer:
    - If skid_valid: main loads from skid, and skid loads the new input if an input transfer occurs.
    - Otherwise: main loads the new input if an input transfer occurs, else out_valid←0.
  - Main register full and no output transfer: an input transfer loads the skid entry.
- Results stay in order; a result is never lost or duplicated.
- out_data/out_tag hold their value while out_valid=1 && out_ready=0.
- flush=1 clears out_valid and skid_valid. Any input presented that cycle is discarded, even if in_ready=1. Data registers may retain stale values.
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, skid_valid=0, out_data=0, out_tag=0.
  - in_ready=0 while rst_n is low.
- Reset takes priority over flush.
- Reset mid-stream discards all held entries.

## Timing
- Latency: an input accepted at edge N appears on out_data/out_valid after edge N. A value is visible in the cycle after its acceptance.
- Throughput: one result per cycle while out_ready=1.
- Sustained back-pressure:
  - At most two entries are held (main + skid).
  - in_ready falls in the cycle after the skid entry fills.
  - in_ready rises in the cycle after the skid entry drains into main.
- Simultaneous input transfer and output transfer with the skid empty: main is replaced and there is no bubble.
- Simultaneous flush and out_ready: the flush wins, and the entry presented that cycle is treated as consumed.

## Test plan
- Modes (IN_W=16, OUT_W=32, SHIFT=2), out_ready=1, each a single beat:
  - imm 0x8001 with op 00 → 0x00008001; op 01 → 0xFFFF8001; op 10 → 0x80010000; op 11 → 0xFFFE0004.
  - imm 0x7FFF with op 11 → 0x0001FFFC.
  - Each result appears one cycle after acceptance.
- Streaming: 8 back-to-back inputs with tags 0–7 and out_ready held at 1 → 8 consecutive out_valid cycles, tags in order, in_ready constantly 1.
- Back-pressure: out_ready=0 while 3 inputs are offered →
  - The first two are accepted, and in_ready=0 from the cycle after the second.
  - Raise out_ready → tags emerge 0, 1, then input 2 is accepted and emerges. No loss, no duplication.
- Flush: with main and skid full, assert flush together with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
- Reset: drive rst_n=0 mid-stream with 2 entries held → after the edge out_valid=0, out_data=0, out_tag=0; in_ready=0 during reset and 1 the first cycle after release.
- Parameter sweep: IN_W=12, OUT_W=24, SHIFT=1 with imm 0x800 → op 01 gives 0xFFF800; op 11 gives 0xFFF000; op 10 gives 0x800000.
